nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple slice per clock.
//  The slice is built from four full_adder instances.

---
 rtl/nibble_serial_adder.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice (four full adders) is
// reused once per clock, LSB nibble first, with a carry register between passes.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [KW-1:0]    k_q, k_d;

    logic [KW+1:0]    shamt;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic [4:0]       carry_chain;
    logic             last_slice;
    logic [WIDTH-1:0] nib_mask;

    // Slice operands are selected by the pass index; bit offset = 4*k.
    assign shamt      = {k_q, 2'b00};
    assign nib_a      = 4'(a_q >> shamt);
    assign nib_b      = 4'(b_q >> shamt);
    assign nib_mask   = WIDTH'(4'hF) << shamt;
    assign last_slice = (k_q == KW'(NSLICE - 1));

    assign carry_chain[0] = carry_q;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a_i (nib_a[i]),
            .b_i (nib_b[i]),
            .c_i (carry_chain[i]),
            .s_o (nib_s[i]),
            .c_o (carry_chain[i+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        k_d         = k_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = (sum_q & ~nib_mask) | (WIDTH'(nib_s) << shamt);
                carry_d = carry_chain[4];
                if (last_slice) begin
                    cout_d      = carry_chain[4];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            k_q         <= k_d;
        end
    end

    // Operand registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16.

module tb_nibble_serial_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Ticks until out_valid is seen, at most 10 cycles; returns cycles waited.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc++;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] exp_s, input logic exp_c);
        int cyc;
        a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_s));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
        tick();
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(exp_s));
    endtask

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sum",       32'(sum),       32'h0000);
        chk("rst_cout",      32'(cout),      32'd0);
        rst = 1'b0;

        run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("cin_nib",    16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0);
        run_op("max_all",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run_op("msb_carry",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: result held for 5 cycles while a new operand set waits.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_latency", 32'(cyc), 32'd4);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_vld_hold",  32'(out_valid), 32'd1);
            chk("bp_sum_hold",  32'(sum),       32'h3333);
            chk("bp_cout_hold", 32'(cout),      32'd0);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_vld",   32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_new_accept", 32'(busy), 32'd1);
        wait_valid(cyc);
        chk("bp_new_latency", 32'(cyc),  32'd4);
        chk("bp_new_sum",     32'(sum),  32'hFFFF);
        chk("bp_new_cout",    32'(cout), 32'd0);
        tick();

        // Reset during the second ADD cycle aborts the operation.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",     32'(busy),      32'd0);
        chk("abort_in_ready", 32'(in_ready),  32'd1);
        chk("abort_vld",      32'(out_valid), 32'd0);
        chk("abort_sum",      32'(sum),       32'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_emit", 32'(out_valid), 32'd0);
        end
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
